pkt_desc_sched: RTL and testbench
=================================

# pkt_desc_sched

Descriptor scheduler sitting between the HPS-facing Avalon-MM CSR slave and the packet read controller. Software queues packet descriptors (begin address, end address, control word). The block issues them one at a time as start pulses with stable address and control outputs, waits for the read controller's done pulse, and enforces a watchdog timeout. It also gates issue on downstream FIFO back-pressure and reports progress and errors through status registers and an interrupt.

## Interface
- DESC_DEPTH, 8: descriptor FIFO depth; power of 2, 2..128.
- TIMEOUT_CYCLES, 65535: number of cycles in WAIT before a transfer is aborted; 1..2^24-1.

- clk  in  1  single clock
- reset  in  1  asynchronous, active-high reset
- avs_address  in  3  CSR word address
- avs_write  in  1  CSR write strobe
- avs_writedata  in  32  CSR write data
- avs_read  in  1  CSR read strobe
- avs_readdata  out  32  CSR read data; valid 1 cycle after avs_read
- rd_ctrl  out  1  start pulse to the read controller
- control  out  32  control word of the current descriptor
- pkt_begin  out  32  begin byte address of the current descriptor
- pkt_end  out  32  end byte address of the current descriptor (exclusive)
- rd_ctrl_rdy  in  1  one-cycle done pulse from the read controller
- almost_full  in  1  downstream packet FIFO back-pressure
- irq  out  1  level interrupt = irq_pending & irq_en

## Operation
- CSR map (word addresses):
  - 0 CTRL, R/W: bit0 enable, bit1 irq_en, bit2 flush (write-only, self-clearing), bits[31:8] ctl_field.
  - 1 DESC_BEGIN, W: latches a begin address into a staging register.
  - 2 DESC_END, W: pushes the descriptor {CTRL[31:8]<<8, staging begin, writedata}.
  - 3 STATUS, R: bit0 busy (state≠IDLE), bit1 full, bit2 empty, bit3 timeout_err, bit4 irq_pending, bit5 bad_desc, bit6 overflow, bits[15:8] occupancy, bits[31:16] done_count.
  - 4 CLEAR, W1C: clears STATUS bits 3..6 for each 1 written.
  - Reads of unmapped addresses return 0. Writes to unmapped addresses are ignored.
- Push validation, all checked on the DESC_END write:
  - end ≤ begin: descriptor dropped, bad_desc set.
  - end − begin > 65535: descriptor dropped, bad_desc set.
  - FIFO full, using the pre-cycle count: descriptor dropped, overflow set, even if a pop occurs in the same cycle.
- A push and a pop in the same cycle are both performed; occupancy is unchanged.
- FSM states: IDLE, ISSUE, WAIT, GAP.
  - IDLE → ISSUE when enable & !empty & !almost_full.
  - ISSUE (1 cycle): rd_ctrl=1. control, pkt_begin and pkt_end are loaded from the FIFO head at the ISSUE entry edge. The FIFO is popped. → WAIT.
  - WAIT:
    - On rd_ctrl_rdy: done_count += 1 (16-bit, wraps), irq_pending set. → GAP.
    - Otherwise, when the timer reaches TIMEOUT_CYCLES: timeout_err set, done_count unchanged. → GAP.
    - If rd_ctrl_rdy and timeout coincide, completion wins.
  - GAP (2 cycles): lets the read controller return to its idle state. → IDLE.
- control, pkt_begin and pkt_end hold their value from ISSUE until the next ISSUE.
- rd_ctrl_rdy outside WAIT is ignored.
- Clearing enable mid-transfer: the in-flight transfer completes or times out; nothing further is issued.
- Flush: empties the FIFO in the write cycle and does not affect the in-flight transfer. A flush in the same cycle as a DESC_END push discards that push.
- almost_full is sampled only in IDLE; it never aborts a transfer already issued.

## Timing
- Reset values: all outputs 0, state IDLE, FIFO empty, all CSR fields 0.
- avs_readdata is registered with 1-cycle read latency and holds its value between reads.
- DESC_END write at cycle 0 with enable set and the FSM idle: occupancy updates at 1, rd_ctrl=1 in cycle 2.
- rd_ctrl is high for exactly 1 cycle per descriptor, and pkt_begin, pkt_end and control are valid in that same cycle.
- rd_ctrl_rdy at cycle T: GAP occupies T+1 and T+2, IDLE is at T+3, and the next rd_ctrl is at T+4 at the earliest.
- Minimum rd_ctrl spacing is 5 cycles.
- The WAIT timer starts at 0 on entry to WAIT. Timeout fires in the cycle the timer equals TIMEOUT_CYCLES.
- STATUS and irq reflect updates 1 cycle after the causing event.
- A W1C write in the same cycle as a setting event leaves the bit set.
- Asserting reset mid-transfer forces everything to reset values immediately. Queued descriptors are lost.

## Test plan
- Single descriptor: enable=1, push begin 0x1000 / end 0x1040 → rd_ctrl 1 cycle with pkt_begin=0x1000, pkt_end=0x1040; after rdy pulse, done_count=1, irq=1 if irq_en.
- Back-to-back queue: push 3 descriptors, return rdy 10 cycles after each rd_ctrl → 3 rd_ctrl pulses in FIFO order, spacing ≥5 cycles, final occupancy 0, done_count=3.
- Back-pressure: almost_full=1 with 2 descriptors queued → no rd_ctrl; deassert → issue within 2 cycles.
- Timeout: TIMEOUT_CYCLES=20, never assert rdy → timeout_err=1 after 20 WAIT cycles, done_count unchanged, next descriptor issued; W1C 0x8 → bit cleared.
- Bad and overflow pushes:
  - end=begin → bad_desc=1, no push.
  - DESC_DEPTH+1 pushes with enable=0 → overflow=1, occupancy=DESC_DEPTH.
- Flush and reset: flush during WAIT → occupancy 0, in-flight transfer still completes; reset asserted during WAIT → all outputs 0 in the same cycle, STATUS reads 0x00000004.

Source files
------------

// File: rtl/pkt_desc_sched.sv
// Descriptor scheduler: queues software descriptors, issues them one at a time to the
// packet read controller with a completion watchdog, and reports status over Avalon-MM.
module pkt_desc_sched #(
  parameter int DESC_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  avs_address,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  output logic        rd_ctrl,
  output logic [31:0] control,
  output logic [31:0] pkt_begin,
  output logic [31:0] pkt_end,
  input  logic        rd_ctrl_rdy,
  input  logic        almost_full,
  output logic        irq
);
  localparam int AW = (DESC_DEPTH > 1) ? $clog2(DESC_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DESC_DEPTH);
  localparam logic [23:0]   TO_C    = 24'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_t;
  state_t state, state_n;

  logic        enable, irq_en;
  logic [23:0] ctl_field;
  logic [31:0] staging;
  logic        timeout_err, irq_pending, bad_desc, overflow;
  logic [15:0] done_count;
  logic [95:0] mem [DESC_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [23:0] timer;
  logic        gap_cnt;

  logic        wr_ctrl, wr_begin, wr_end, wr_clear, flush;
  logic        desc_bad, full, empty, push, pop, done_evt, to_evt;
  logic [31:0] span, status;

  always_comb begin
    wr_ctrl  = avs_write && (avs_address == 3'd0);
    wr_begin = avs_write && (avs_address == 3'd1);
    wr_end   = avs_write && (avs_address == 3'd2);
    wr_clear = avs_write && (avs_address == 3'd4);
    flush    = wr_ctrl && avs_writedata[2];
    span     = avs_writedata - staging;
    desc_bad = (avs_writedata <= staging) || (span > 32'd65535);
    full     = (count == DEPTH_C);
    empty    = (count == '0);
    // Full is judged on the pre-cycle count, so a same-cycle pop never rescues a push.
    push     = wr_end && !desc_bad && !full && !flush;
    pop      = (state == ISSUE) && !empty && !flush;
  end

  always_comb begin
    state_n  = state;
    done_evt = 1'b0;
    to_evt   = 1'b0;
    case (state)
      IDLE:  if (enable && !empty && !almost_full) state_n = ISSUE;
      ISSUE: state_n = WAIT;
      WAIT: begin
        if (rd_ctrl_rdy) begin
          done_evt = 1'b1;
          state_n  = GAP;
        end else if (timer == TO_C) begin
          to_evt  = 1'b1;
          state_n = GAP;
        end
      end
      GAP:   if (gap_cnt) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      gap_cnt <= 1'b0;
      timer   <= '0;
    end else begin
      state   <= state_n;
      gap_cnt <= (state == GAP) ? ~gap_cnt : 1'b0;
      timer   <= (state == WAIT) ? timer + 24'd1 : 24'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      control   <= '0;
      pkt_begin <= '0;
      pkt_end   <= '0;
    end else if (state == IDLE && state_n == ISSUE) begin
      {control, pkt_begin, pkt_end} <= mem[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {ctl_field, 8'h00, staging, avs_writedata};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Sticky status bits: a setting event in the same cycle as a W1C wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable      <= 1'b0;
      irq_en      <= 1'b0;
      ctl_field   <= '0;
      staging     <= '0;
      timeout_err <= 1'b0;
      irq_pending <= 1'b0;
      bad_desc    <= 1'b0;
      overflow    <= 1'b0;
      done_count  <= '0;
    end else begin
      if (wr_ctrl) begin
        enable    <= avs_writedata[0];
        irq_en    <= avs_writedata[1];
        ctl_field <= avs_writedata[31:8];
      end
      if (wr_begin) staging <= avs_writedata;
      if (done_evt) done_count <= done_count + 16'd1;
      timeout_err <= to_evt | (timeout_err & ~(wr_clear & avs_writedata[3]));
      irq_pending <= done_evt | (irq_pending & ~(wr_clear & avs_writedata[4]));
      bad_desc    <= (wr_end & desc_bad) | (bad_desc & ~(wr_clear & avs_writedata[5]));
      overflow    <= (wr_end & !desc_bad & full) | (overflow & ~(wr_clear & avs_writedata[6]));
    end
  end

  assign status = {done_count, 8'(count), 1'b0, overflow, bad_desc, irq_pending,
                   timeout_err, empty, full, (state != IDLE)};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      avs_readdata <= '0;
    end else if (avs_read) begin
      case (avs_address)
        3'd0:    avs_readdata <= {ctl_field, 6'b0, irq_en, enable};
        3'd3:    avs_readdata <= status;
        default: avs_readdata <= '0;
      endcase
    end
  end

  assign rd_ctrl = (state == ISSUE);
  assign irq     = irq_pending & irq_en;
endmodule

// File: tb/tb_pkt_desc_sched.sv
// Directed bench for pkt_desc_sched: inputs driven and outputs sampled on the falling edge.
module tb_pkt_desc_sched;
  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  avs_address;
  logic        avs_write, avs_read;
  logic [31:0] avs_writedata, avs_readdata;
  logic        rd_ctrl, rd_ctrl_rdy, almost_full, irq;
  logic [31:0] control, pkt_begin, pkt_end;
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pkt_desc_sched #(.DESC_DEPTH(8), .TIMEOUT_CYCLES(20)) dut (
    .clk(clk), .reset(reset), .avs_address(avs_address), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_read(avs_read), .avs_readdata(avs_readdata),
    .rd_ctrl(rd_ctrl), .control(control), .pkt_begin(pkt_begin), .pkt_end(pkt_end),
    .rd_ctrl_rdy(rd_ctrl_rdy), .almost_full(almost_full), .irq(irq)
  );

  task automatic csr_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk); avs_address = a; avs_writedata = d; avs_write = 1'b1;
    @(negedge clk); avs_write = 1'b0;
  endtask

  task automatic csr_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk); avs_address = a; avs_read = 1'b1;
    @(negedge clk); avs_read = 1'b0; d = avs_readdata;
  endtask

  task automatic push(input logic [31:0] b, input logic [31:0] e);
    csr_write(3'd1, b);
    csr_write(3'd2, e);
  endtask

  task automatic pulse_rdy();
    @(negedge clk); rd_ctrl_rdy = 1'b1;
    @(negedge clk); rd_ctrl_rdy = 1'b0;
  endtask

  task automatic wait_issue(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (rd_ctrl) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1; avs_address = '0; avs_write = 0; avs_read = 0; avs_writedata = '0;
    rd_ctrl_rdy = 0; almost_full = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({rd_ctrl, irq, control, pkt_begin, pkt_end, avs_readdata} !== '0) begin
      errors++; $display("FAIL reset_outputs: got nonzero rd_ctrl=%b irq=%b ctl=%h b=%h e=%h rd=%h",
                         rd_ctrl, irq, control, pkt_begin, pkt_end, avs_readdata);
    end
    reset = 1'b0;
    csr_read(3'd3, d);
    checks++; if (d !== 32'h4) begin errors++; $display("FAIL reset_status: got %h expected %h", d, 32'h4); end
    csr_read(3'd0, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_ctrl: got %h expected %h", d, 32'h0); end
  endtask

  task automatic test_single();
    logic [31:0] d;
    csr_write(3'd0, 32'h00ABCD03);
    push(32'h1000, 32'h1040);
    checks++; if (rd_ctrl !== 1'b0) begin errors++; $display("FAIL single_early: rd_ctrl got %b expected 0", rd_ctrl); end
    @(negedge clk);
    checks++;
    if ({rd_ctrl, pkt_begin, pkt_end, control} !== {1'b1, 32'h1000, 32'h1040, 32'h00ABCD00}) begin
      errors++; $display("FAIL single_issue: got rd=%b b=%h e=%h c=%h expected 1 1000 1040 00abcd00",
                         rd_ctrl, pkt_begin, pkt_end, control);
    end
    @(negedge clk);
    checks++; if (rd_ctrl !== 1'b0) begin errors++; $display("FAIL single_pulse_width: rd_ctrl got %b expected 0", rd_ctrl); end
    csr_read(3'd3, d);
    checks++; if (d !== 32'h5) begin errors++; $display("FAIL single_wait_status: got %h expected %h", d, 32'h5); end
    pulse_rdy();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL single_irq: got %b expected 1", irq); end
    csr_read(3'd3, d);
    checks++; if (d !== 32'h00010015) begin errors++; $display("FAIL single_done_status: got %h expected %h", d, 32'h00010015); end
    csr_write(3'd4, 32'h10);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL single_irq_clear: got %b expected 0", irq); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic [31:0] eb [3] = '{32'h2000, 32'h3000, 32'h4000};
    logic [31:0] ee [3] = '{32'h2010, 32'h3100, 32'h4004};
    bit ok;
    int last = 0;
    csr_write(3'd0, 32'h00001200);
    for (int n = 0; n < 3; n++) push(eb[n], ee[n]);
    csr_write(3'd0, 32'h00000001);
    for (int n = 0; n < 3; n++) begin
      wait_issue(20, ok);
      checks++; if (!ok) begin errors++; $display("FAIL b2b_issue%0d: no rd_ctrl within 20 cycles", n); end
      if (n > 0) begin
        checks++; if (cyc - last !== 14) begin errors++; $display("FAIL b2b_spacing%0d: got %0d expected 14", n, cyc - last); end
      end
      last = cyc;
      checks++;
      if ({pkt_begin, pkt_end, control} !== {eb[n], ee[n], 32'h00001200}) begin
        errors++; $display("FAIL b2b_desc%0d: got b=%h e=%h c=%h expected b=%h e=%h c=00001200",
                           n, pkt_begin, pkt_end, control, eb[n], ee[n]);
      end
      repeat (9) @(negedge clk);
      pulse_rdy();
    end
    repeat (4) @(negedge clk);
    csr_read(3'd3, d);
    checks++; if (d !== 32'h00040014) begin errors++; $display("FAIL b2b_status: got %h expected %h", d, 32'h00040014); end
    csr_write(3'd4, 32'h10);
  endtask

  task automatic test_backpressure();
    logic [31:0] d;
    bit ok, seen;
    csr_write(3'd0, 32'h0);
    push(32'h5000, 32'h5020);
    push(32'h6000, 32'h6040);
    almost_full = 1'b1;
    csr_write(3'd0, 32'h1);
    seen = 0;
    repeat (10) begin @(negedge clk); if (rd_ctrl) seen = 1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL bp_blocked: rd_ctrl got 1 expected 0"); end
    almost_full = 1'b0;
    wait_issue(3, ok);
    checks++;
    if (!ok || pkt_begin !== 32'h5000) begin
      errors++; $display("FAIL bp_release: got issued=%b b=%h expected 1 5000", ok, pkt_begin);
    end
    @(negedge clk); almost_full = 1'b1;
    repeat (2) @(negedge clk);
    pulse_rdy();
    seen = 0;
    repeat (6) begin @(negedge clk); if (rd_ctrl) seen = 1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL bp_blocked2: rd_ctrl got 1 expected 0"); end
    almost_full = 1'b0;
    wait_issue(3, ok);
    checks++;
    if (!ok || pkt_begin !== 32'h6000) begin
      errors++; $display("FAIL bp_second: got issued=%b b=%h expected 1 6000", ok, pkt_begin);
    end
    repeat (2) @(negedge clk);
    pulse_rdy();
    repeat (4) @(negedge clk);
    csr_read(3'd3, d);
    checks++; if (d !== 32'h00060014) begin errors++; $display("FAIL bp_status: got %h expected %h", d, 32'h00060014); end
    csr_write(3'd4, 32'h10);
  endtask

  task automatic test_timeout();
    logic [31:0] d;
    bit ok;
    int c;
    csr_write(3'd0, 32'h0);
    push(32'h7000, 32'h7010);
    push(32'h8000, 32'h8800);
    csr_write(3'd0, 32'h1);
    wait_issue(5, ok);
    checks++; if (!ok) begin errors++; $display("FAIL to_first_issue: no rd_ctrl within 5 cycles"); end
    c = cyc;
    @(negedge clk);
    wait_issue(40, ok);
    checks++;
    if (!ok || (cyc - c) !== 25 || pkt_begin !== 32'h8000) begin
      errors++; $display("FAIL to_next_issue: got issued=%b gap=%0d b=%h expected 1 25 8000", ok, cyc - c, pkt_begin);
    end
    csr_read(3'd3, d);
    checks++; if (d !== 32'h0006000D) begin errors++; $display("FAIL to_status: got %h expected %h", d, 32'h0006000D); end
    csr_write(3'd4, 32'h8);
    csr_read(3'd3, d);
    checks++; if (d !== 32'h00060005) begin errors++; $display("FAIL to_w1c: got %h expected %h", d, 32'h00060005); end
    pulse_rdy();
    repeat (4) @(negedge clk);
    csr_read(3'd3, d);
    checks++; if (d !== 32'h00070014) begin errors++; $display("FAIL to_done: got %h expected %h", d, 32'h00070014); end
    csr_write(3'd4, 32'h10);
  endtask

  task automatic test_bad_overflow();
    logic [31:0] d;
    csr_write(3'd0, 32'h0);
    push(32'h100, 32'h100);
    csr_read(3'd3, d);
    checks++; if (d !== 32'h00070024) begin errors++; $display("FAIL bad_equal: got %h expected %h", d, 32'h00070024); end
    csr_write(3'd4, 32'h20);
    push(32'h0, 32'h10000);
    csr_read(3'd3, d);
    checks++; if (d !== 32'h00070024) begin errors++; $display("FAIL bad_span: got %h expected %h", d, 32'h00070024); end
    csr_write(3'd4, 32'h20);
    push(32'h0, 32'hFFFF);
    csr_read(3'd3, d);
    checks++; if (d !== 32'h00070100) begin errors++; $display("FAIL max_span: got %h expected %h", d, 32'h00070100); end
    repeat (8) csr_write(3'd2, 32'hFFFF);
    csr_read(3'd3, d);
    checks++; if (d !== 32'h00070842) begin errors++; $display("FAIL overflow: got %h expected %h", d, 32'h00070842); end
  endtask

  task automatic test_flush();
    logic [31:0] d;
    bit ok, seen;
    csr_write(3'd4, 32'h40);
    csr_write(3'd0, 32'h1);
    wait_issue(5, ok);
    checks++;
    if (!ok || pkt_end !== 32'hFFFF) begin errors++; $display("FAIL flush_issue: got issued=%b e=%h expected 1 ffff", ok, pkt_end); end
    csr_write(3'd0, 32'h5);
    csr_read(3'd3, d);
    checks++; if (d !== 32'h00070005) begin errors++; $display("FAIL flush_status: got %h expected %h", d, 32'h00070005); end
    pulse_rdy();
    seen = 0;
    repeat (4) begin @(negedge clk); if (rd_ctrl) seen = 1; end
    csr_read(3'd3, d);
    checks++;
    if (d !== 32'h00080014 || seen) begin errors++; $display("FAIL flush_done: got %h reissue=%b expected 00080014 0", d, seen); end
    csr_read(3'd0, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL flush_selfclear: got %h expected %h", d, 32'h1); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    bit ok;
    csr_write(3'd0, 32'h3);
    push(32'h9000, 32'h9100);
    wait_issue(5, ok);
    @(negedge clk);
    checks++;
    if (!ok || irq !== 1'b1) begin errors++; $display("FAIL rst_pre: got issued=%b irq=%b expected 1 1", ok, irq); end
    reset = 1'b1;
    #1;
    checks++;
    if ({rd_ctrl, irq, control, pkt_begin, pkt_end, avs_readdata} !== '0) begin
      errors++; $display("FAIL rst_mid_outputs: got rd=%b irq=%b c=%h b=%h e=%h rd=%h expected all 0",
                         rd_ctrl, irq, control, pkt_begin, pkt_end, avs_readdata);
    end
    @(negedge clk); reset = 1'b0;
    csr_read(3'd3, d);
    checks++; if (d !== 32'h4) begin errors++; $display("FAIL rst_mid_status: got %h expected %h", d, 32'h4); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_timeout();
    test_bad_overflow();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
